// File: rtl/pulse_gen_mc.sv
// pulse_gen_mc: multi-channel programmable pulse generator.
// Each channel accepts a trigger, waits a latched delay, then drives a pulse of
// latched length. Per-channel modes: ONESHOT, RETRIG and PERIODIC.
// Optional build macro PULSE_GEN_EDGE_EN: when defined, the trigger is the rising
// edge of en instead of its level. PERIODIC continuation always uses the en level.
module pulse_gen_mc #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CH-1:0]             en,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   cfg_len,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   cfg_delay,
    input  logic [2*NUM_CH-1:0]           cfg_mode,
    output logic [NUM_CH-1:0]             out_pulse,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             done
);

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_RETRIG   = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    // Mode code 11 is reserved and behaves as ONESHOT.
    function automatic logic [1:0] decode_mode(input logic [1:0] raw);
        logic [1:0] res;
        case (raw)
            2'b01:   res = MODE_RETRIG;
            2'b10:   res = MODE_PERIODIC;
            default: res = MODE_ONESHOT;
        endcase
        return res;
    endfunction

    logic [NUM_CH-1:0] w_trig;

`ifdef PULSE_GEN_EDGE_EN
    logic [NUM_CH-1:0] r_en_q;

    // Delayed copy of en used to detect rising edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en_q <= {NUM_CH{1'b0}};
        end else begin
            r_en_q <= en;
        end
    end

    assign w_trig = en & ~r_en_q;
`else
    assign w_trig = en;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] r_len;
        logic [CNT_WIDTH-1:0] r_delay;
        logic [1:0]           r_mode;
        logic                 r_out;
        logic                 r_busy;
        logic                 r_done;

        logic [CNT_WIDTH-1:0] w_cfg_len;
        logic [CNT_WIDTH-1:0] w_cfg_delay;
        logic [1:0]           w_cfg_mode;
        logic                 w_act_last;
        logic                 w_dly_last;

        assign w_cfg_len   = cfg_len[g*CNT_WIDTH +: CNT_WIDTH];
        assign w_cfg_delay = cfg_delay[g*CNT_WIDTH +: CNT_WIDTH];
        assign w_cfg_mode  = decode_mode(cfg_mode[2*g +: 2]);
        // Latched len is never zero while DELAY/ACTIVE, so len-1 does not wrap there.
        assign w_act_last  = (r_cnt == (r_len - CNT_ONE));
        assign w_dly_last  = (r_cnt == (r_delay - CNT_ONE));

        // Per-channel FSM: IDLE -> DELAY -> ACTIVE -> IDLE with registered outputs.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_state <= ST_IDLE;
                r_cnt   <= CNT_ZERO;
                r_len   <= CNT_ZERO;
                r_delay <= CNT_ZERO;
                r_mode  <= MODE_ONESHOT;
                r_out   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_done <= 1'b0;
                        r_cnt  <= CNT_ZERO;
                        if (w_trig[g] && (w_cfg_len != CNT_ZERO)) begin
                            r_len   <= w_cfg_len;
                            r_delay <= w_cfg_delay;
                            r_mode  <= w_cfg_mode;
                            r_busy  <= 1'b1;
                            if (w_cfg_delay != CNT_ZERO) begin
                                r_state <= ST_DELAY;
                                r_out   <= 1'b0;
                            end else begin
                                r_state <= ST_ACTIVE;
                                r_out   <= 1'b1;
                            end
                        end else begin
                            r_out  <= 1'b0;
                            r_busy <= 1'b0;
                        end
                    end
                    ST_DELAY: begin
                        // Triggers are ignored while waiting out the delay.
                        r_done <= 1'b0;
                        if (w_dly_last) begin
                            r_state <= ST_ACTIVE;
                            r_cnt   <= CNT_ZERO;
                            r_out   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    ST_ACTIVE: begin
                        if ((r_mode == MODE_RETRIG) && w_trig[g]) begin
                            // Retrigger wins over ending, even on the final cycle.
                            r_cnt  <= CNT_ZERO;
                            r_done <= 1'b0;
                        end else if (w_act_last) begin
                            r_done <= 1'b1;
                            r_cnt  <= CNT_ZERO;
                            if ((r_mode == MODE_PERIODIC) && en[g]) begin
                                if (r_delay != CNT_ZERO) begin
                                    r_state <= ST_DELAY;
                                    r_out   <= 1'b0;
                                end else begin
                                    r_state <= ST_ACTIVE;
                                    r_out   <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_IDLE;
                                r_out   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt  <= r_cnt + CNT_ONE;
                            r_done <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end

        assign out_pulse[g] = r_out;
        assign busy[g]      = r_busy;
        assign done[g]      = r_done;
    end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Scoreboard bench for pulse_gen_mc: a time-window reference model predicts
// per-cycle outputs, a monitor pops and compares them one cycle at a time.
module tb_pulse_gen_mc;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic              clk;
    logic              rstn;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] cfg_len;
    logic [NCH*CW-1:0] cfg_delay;
    logic [2*NCH-1:0]  cfg_mode;
    logic [NCH-1:0]    out_pulse;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    pulse_gen_mc #(.NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .cfg_len   (cfg_len),
        .cfg_delay (cfg_delay),
        .cfg_mode  (cfg_mode),
        .out_pulse (out_pulse),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] o;
        logic [NCH-1:0] b;
        logic [NCH-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Programmed configuration (what the bench drives onto cfg_*).
    int lenv[NCH];
    int dlyv[NCH];
    int modev[NCH];

    // Reference model: each channel holds an absolute busy window.
    int             n = 0;
    bit             sched[NCH];
    int             t_start[NCH];
    int             t_end[NCH];
    int             mlen[NCH];
    int             mdly[NCH];
    int             mmode[NCH];
    logic [NCH-1:0] prev_en;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) sched[c] = 1'b0;
        prev_en = '0;
    endtask

    task automatic drive_cfg();
        for (int c = 0; c < NCH; c++) begin
            cfg_len[c*CW +: CW]   = CW'(lenv[c]);
            cfg_delay[c*CW +: CW] = CW'(dlyv[c]);
            cfg_mode[2*c +: 2]    = 2'(modev[c]);
        end
    endtask

    // One clock: apply inputs for edge n and queue the prediction for cycle n+1.
    task automatic step(input logic [NCH-1:0] en_in);
        exp_t e;
        bit   trig;
        @(negedge clk);
        rstn = 1'b1;
        en   = en_in;
        drive_cfg();
        e.cyc = n + 1;
        e.d   = '0;
        for (int c = 0; c < NCH; c++) begin
`ifdef PULSE_GEN_EDGE_EN
            trig = en_in[c] & ~prev_en[c];
`else
            trig = en_in[c];
`endif
            if (sched[c] && n <= t_end[c]) begin
                if (mmode[c] == 1 && n >= t_start[c] && trig) begin
                    t_end[c] = n + mlen[c];
                end else if (n == t_end[c]) begin
                    e.d[c] = 1'b1;
                    if (mmode[c] == 2 && en_in[c]) begin
                        t_start[c] = n + 1 + mdly[c];
                        t_end[c]   = n + mdly[c] + mlen[c];
                    end else begin
                        sched[c] = 1'b0;
                    end
                end
            end else if (trig && lenv[c] != 0) begin
                mlen[c]    = lenv[c];
                mdly[c]    = dlyv[c];
                mmode[c]   = (modev[c] == 3) ? 0 : modev[c];
                sched[c]   = 1'b1;
                t_start[c] = n + 1 + mdly[c];
                t_end[c]   = n + mdly[c] + mlen[c];
            end
            e.b[c] = sched[c] && (n + 1 <= t_end[c]);
            e.o[c] = sched[c] && (t_start[c] <= n + 1) && (n + 1 <= t_end[c]);
        end
        prev_en = en_in;
        exp_q.push_back(e);
        n++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step('0);
    endtask

    // Reset cycles: outputs must clear immediately, and stay clear next cycle.
    task automatic do_reset(input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            rstn = 1'b0;
            en   = '0;
            #1;
            checks++;
            if ({out_pulse, busy, done} !== {3*NCH{1'b0}}) begin
                errors++;
                $display("FAIL reset_async cyc=%0d got out=%b busy=%b done=%b want all 0",
                         n, out_pulse, busy, done);
            end
            model_reset();
            e.cyc = n + 1;
            e.o = '0;
            e.b = '0;
            e.d = '0;
            exp_q.push_back(e);
            n++;
        end
    endtask

    task automatic set_ch(input int c, input int l, input int d, input int m);
        lenv[c]  = l;
        dlyv[c]  = d;
        modev[c] = m;
    endtask

    // Monitor: compare the DUT against the next queued prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_pulse !== e.o || busy !== e.b || done !== e.d) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d got out=%b busy=%b done=%b want out=%b busy=%b done=%b",
                             e.cyc, out_pulse, busy, done, e.o, e.b, e.d);
                end
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        en        = '0;
        cfg_len   = '0;
        cfg_delay = '0;
        cfg_mode  = '0;
        for (int c = 0; c < NCH; c++) set_ch(c, 0, 0, 0);
        model_reset();
        do_reset(3);

        // ch0 ONESHOT len=3 D=0
        set_ch(0, 3, 0, 0);
        step(4'b0001); idle(6);
        // ch1 ONESHOT len=4 D=2, second en ignored while busy
        set_ch(1, 4, 2, 0);
        step(4'b0010); idle(3); step(4'b0010); idle(6);
        // ch2 RETRIG len=5 D=0, en at 0 and 3
        set_ch(2, 5, 0, 1);
        step(4'b0100); idle(2); step(4'b0100); idle(8);
        // ch3 PERIODIC len=2 D=1, en held 8 cycles
        set_ch(3, 2, 1, 2);
        for (int i = 0; i < 8; i++) step(4'b1000);
        idle(6);
        // zero length ignored; reset mid-ACTIVE
        set_ch(0, 0, 0, 0);
        step(4'b0001); idle(3);
        set_ch(0, 10, 0, 0);
        step(4'b0001); idle(4);
        do_reset(2);
        idle(3);
        // en held high, ONESHOT len=2
        set_ch(0, 2, 0, 0);
        for (int i = 0; i < 10; i++) step(4'b0001);
        idle(4);
        // maximum delay and length
        set_ch(1, 255, 255, 0);
        step(4'b0010); idle(515);
        // simultaneous triggers, all modes, PERIODIC with D=0 held
        set_ch(0, 1, 0, 0); set_ch(1, 1, 0, 1); set_ch(2, 3, 0, 2); set_ch(3, 2, 0, 3);
        for (int i = 0; i < 7; i++) step(4'b1111);
        idle(6);
        // retrigger on the final active cycle
        set_ch(2, 3, 1, 1);
        step(4'b0100); idle(3); step(4'b0100); idle(6);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [NCH-1:0] r_en;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0)
                    set_ch(c, $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3));
                r_en[c] = ($urandom_range(0, 9) < 3);
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                step(r_en);
            end
        end
        idle(40);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
